// File: rtl/dem_counter_pkg.sv
// Shared encodings for the dem up/down counter: MODE values and the two
// small FSMs (ping-pong direction, one-shot progress).
package dem_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_ONESHOT  = 2'b11
  } mode_e;

  typedef enum logic {
    PP_UP   = 1'b0,
    PP_DOWN = 1'b1
  } pp_state_e;

  typedef enum logic {
    OS_RUN = 1'b0,
    OS_FIN = 1'b1
  } os_state_e;

endpackage

// File: rtl/dem_prescaler.sv
// Step-tick generator: TICK is high on every PRESCALE-th enabled edge.
// The phase holds while EN is low and restarts on CLR.
module dem_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic Clk,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int unsigned   CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q;

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST)         cnt_q <= '0;
    else if (CLR)     cnt_q <= '0;
    else if (EN)      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
  end

  // Combinational so that PRESCALE=1 steps on the very edge EN is seen.
  assign TICK = EN && (cnt_q == LAST);

endmodule

// File: rtl/dem_updown_n.sv
// Modulo-MOD up/down counter with wrap, saturate, ping-pong and one-shot
// modes, prescaled stepping, registered TC pulse and sticky OVF.
module dem_updown_n
  import dem_counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MOD      = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             DIR,
  input  logic [1:0]       MODE,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             OVF,
  output logic             DIR_OUT,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] TOP    = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] TOP_M1 = WIDTH'(MOD - 2);
  localparam logic [WIDTH-1:0] ZERO   = '0;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  mode_e            mode, mode_q;
  pp_state_e        pp_q, pp_eff, pp_d;
  os_state_e        os_q, os_d;
  logic [WIDTH-1:0] count_q, count_d, load_val, stepped;
  logic             tc_q, tc_d, ovf_q, ovf_d, ovf_set, done_q, done_d;
  logic             tick, step, up, at_term;

  dem_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clk  (Clk),
    .RST  (RST),
    .EN   (EN),
    .CLR  (LOAD),
    .TICK (tick)
  );

  assign mode     = mode_e'(MODE);
  assign load_val = (32'(LOAD_VAL) >= MOD) ? TOP : LOAD_VAL;

  // Entering ping-pong seeds the direction FSM from DIR on that same edge.
  assign pp_eff  = (mode == MODE_PINGPONG && mode_q != MODE_PINGPONG)
                   ? (DIR ? PP_UP : PP_DOWN) : pp_q;
  assign up      = (mode == MODE_PINGPONG) ? (pp_eff == PP_UP) : DIR;
  assign at_term = up ? (count_q == TOP) : (count_q == ZERO);
  assign stepped = up ? count_q + ONE : count_q - ONE;
  assign step    = tick && !LOAD;

  // State register.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      count_q <= ZERO;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      pp_q    <= PP_UP;
      os_q    <= OS_RUN;
      // Treated as already in ping-pong so reset leaves the FSM at UP.
      mode_q  <= MODE_PINGPONG;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      pp_q    <= pp_d;
      os_q    <= os_d;
      mode_q  <= mode;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default up front so no path infers a latch.
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    done_d  = done_q;
    pp_d    = pp_eff;
    os_d    = os_q;
    if (LOAD) begin
      count_d = load_val;
      os_d    = OS_RUN;
      done_d  = 1'b0;
    end else if (step) begin
      unique case (mode)
        MODE_WRAP: begin
          tc_d    = at_term;
          ovf_set = at_term;
          count_d = at_term ? (up ? ZERO : TOP) : stepped;
        end
        MODE_SAT: begin
          tc_d    = at_term;
          ovf_set = at_term;
          if (!at_term) count_d = stepped;
        end
        MODE_PINGPONG: begin
          if (at_term) begin
            tc_d    = 1'b1;
            pp_d    = up ? PP_DOWN : PP_UP;
            count_d = up ? TOP_M1 : ONE;
          end else begin
            count_d = stepped;
          end
        end
        MODE_ONESHOT: begin
          if (os_q == OS_RUN) begin
            if (at_term) begin
              tc_d   = 1'b1;
              os_d   = OS_FIN;
              done_d = 1'b1;
            end else begin
              count_d = stepped;
            end
          end
        end
      endcase
    end
    // A set on the same edge as a clear leaves the flag high.
    ovf_d = ovf_set || (ovf_q && !CLR_OVF);
  end

  // Outputs.
  assign OUT     = count_q;
  assign TC      = tc_q;
  assign OVF     = ovf_q;
  assign DONE    = done_q;
  assign DIR_OUT = up;

endmodule

// File: tb/tb_dem_updown_n.sv
// Self-checking bench for dem_updown_n: directed vector table, hand-written
// corner sequences, and randomized traffic against a behavioural model.
module tb_dem_updown_n;

  localparam int M  = 10;
  localparam int PS = 1;

  logic       Clk = 1'b0;
  logic       RST, EN, LOAD, DIR, CLR_OVF;
  logic [3:0] LOAD_VAL;
  logic [1:0] MODE;
  logic [3:0] OUT;
  logic       TC, OVF, DIR_OUT, DONE;

  logic       ps_rst, ps_en;
  logic [3:0] ps_out;
  logic       ps_tc, ps_ovf, ps_dir_out, ps_done;

  always #5 Clk = ~Clk;

  dem_updown_n #(.WIDTH(4), .MOD(10), .PRESCALE(1)) dut (
    .Clk(Clk), .RST(RST), .EN(EN), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .DIR(DIR), .MODE(MODE), .CLR_OVF(CLR_OVF), .OUT(OUT), .TC(TC),
    .OVF(OVF), .DIR_OUT(DIR_OUT), .DONE(DONE)
  );

  dem_updown_n #(.WIDTH(4), .MOD(10), .PRESCALE(3)) dut_ps (
    .Clk(Clk), .RST(ps_rst), .EN(ps_en), .LOAD(1'b0), .LOAD_VAL(4'd0),
    .DIR(1'b1), .MODE(2'b00), .CLR_OVF(1'b0), .OUT(ps_out), .TC(ps_tc),
    .OVF(ps_ovf), .DIR_OUT(ps_dir_out), .DONE(ps_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    bit en; bit load; int lv; bit dir; int mode; bit clr;
    int out; bit tc; bit ovf; bit done; bit dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit en, input bit load, input int lv, input bit dir,
                     input int mode, input bit clr, input int out, input bit tc,
                     input bit ovf, input bit done, input bit dout);
    vec_t v;
    v.en = en; v.load = load; v.lv = lv; v.dir = dir; v.mode = mode; v.clr = clr;
    v.out = out; v.tc = tc; v.ovf = ovf; v.done = done; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic drive(input bit en, input bit load, input int lv, input bit dir,
                       input int mode, input bit clr);
    EN = en; LOAD = load; LOAD_VAL = 4'(lv); DIR = dir; MODE = 2'(mode); CLR_OVF = clr;
  endtask

  // Behavioural reference: integer count, sticky flags, a direction bit for
  // ping-pong and a finished bit for one-shot.
  int m_cnt, m_pre, m_prev_mode;
  bit m_ovf, m_done, m_pp_up, m_fin, m_tc;

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_prev_mode = 2;
    m_ovf = 0; m_done = 0; m_pp_up = 1; m_fin = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit en, input bit load, input int lv, input bit dir,
                            input int mode, input bit clr);
    bit tick, up, hit, ovfset;
    int nxt;
    tick = 0; ovfset = 0; m_tc = 0;
    if (mode == 2 && m_prev_mode != 2) m_pp_up = dir;
    if (load) m_pre = 0;
    else if (en) begin
      m_pre++;
      if (m_pre == PS) begin tick = 1; m_pre = 0; end
    end
    if (load) begin
      m_cnt = (lv >= M) ? M - 1 : lv; m_fin = 0; m_done = 0;
    end else if (tick) begin
      up  = (mode == 2) ? m_pp_up : dir;
      nxt = up ? m_cnt + 1 : m_cnt - 1;
      hit = (nxt < 0) || (nxt >= M);
      case (mode)
        0: begin m_cnt = (nxt + M) % M; if (hit) begin m_tc = 1; ovfset = 1; end end
        1: if (hit) begin m_tc = 1; ovfset = 1; end else m_cnt = nxt;
        2: if (hit) begin m_tc = 1; m_pp_up = !m_pp_up; m_cnt = up ? M - 2 : 1; end
           else m_cnt = nxt;
        default: if (!m_fin) begin
             if (hit) begin m_tc = 1; m_fin = 1; m_done = 1; end else m_cnt = nxt;
           end
      endcase
    end
    m_ovf = ovfset | (m_ovf & !clr);
    m_prev_mode = mode;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int tc_cnt, exp_out, mode_r;
    bit dir_r, en_r, load_r, clr_r;
    int lv_r;

    // Wrap up, 11 edges from 0.
    for (int k = 1; k <= 11; k++)
      add(1, 0, 0, 1, 0, 0, k % M, k == 10, k >= 10, 0, 1);
    // Saturate down after a load, with OVF clear and set-wins.
    add(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    add(0, 1, 2, 0, 1, 0, 2, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    // One-shot with load clamp.
    add(1, 1, 15, 1, 3, 0, 9, 0, 0, 0, 1);
    add(1, 0, 0, 1, 3, 0, 9, 1, 0, 1, 1);
    add(1, 0, 0, 1, 3, 0, 9, 0, 0, 1, 1);
    add(1, 0, 0, 1, 3, 0, 9, 0, 0, 1, 1);
    add(1, 1, 3, 1, 3, 0, 3, 0, 0, 0, 1);
    add(1, 0, 0, 1, 3, 0, 4, 0, 0, 0, 1);
    add(0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0);
    // Wrap down through 0, mode change without a step, ping-pong entry from DIR=0.
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 8, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 8, 0, 1, 0, 0);
    add(1, 0, 0, 0, 2, 0, 7, 0, 1, 0, 0);
    add(1, 0, 0, 1, 2, 0, 6, 0, 1, 0, 0);

    // Reset state, with EN high while in reset.
    RST = 1'b0; ps_rst = 1'b0; ps_en = 1'b0;
    drive(1, 0, 0, 1, 0, 0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset out", OUT, 0);
    check("reset tc", TC, 0);
    check("reset ovf", OVF, 0);
    check("reset done", DONE, 0);
    @(negedge Clk);
    RST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].load, vecs[i].lv, vecs[i].dir, vecs[i].mode, vecs[i].clr);
      @(posedge Clk); #1;
      check($sformatf("vec%0d out", i), OUT, vecs[i].out);
      check($sformatf("vec%0d tc", i), TC, vecs[i].tc);
      check($sformatf("vec%0d ovf", i), OVF, vecs[i].ovf);
      check($sformatf("vec%0d done", i), DONE, vecs[i].done);
      check($sformatf("vec%0d dir_out", i), DIR_OUT, vecs[i].dout);
    end

    // Ping-pong from reset: 0..9, 8..0, 1.
    #2 RST = 1'b0;
    drive(1, 0, 0, 1, 2, 0);
    #1 check("pp reset out", OUT, 0);
    @(negedge Clk) RST = 1'b1;
    tc_cnt = 0;
    for (int k = 1; k <= 19; k++) begin
      @(posedge Clk); #1;
      exp_out = (k <= 9) ? k : ((k <= 18) ? 18 - k : 1);
      check($sformatf("pp%0d out", k), OUT, exp_out);
      check($sformatf("pp%0d tc", k), TC, (k == 10 || k == 19) ? 1 : 0);
      check($sformatf("pp%0d dir_out", k), DIR_OUT, (k >= 10 && k <= 18) ? 0 : 1);
      if (TC) tc_cnt++;
    end
    check("pp tc pulses", tc_cnt, 2);

    // Asynchronous reset between edges, at OUT=7 and again during a TC pulse.
    drive(1, 0, 0, 1, 0, 0);
    repeat (6) @(posedge Clk);
    #1 check("async pre out", OUT, 7);
    #2 RST = 1'b0;
    #1 check("async out", OUT, 0);
    check("async tc", TC, 0);
    @(negedge Clk) RST = 1'b1;
    @(posedge Clk); #1 check("async resume out", OUT, 1);
    repeat (9) @(posedge Clk);
    #1 check("async pre tc", TC, 1);
    check("async pre tc out", OUT, 0);
    #2 RST = 1'b0;
    #1 check("async tc cut", TC, 0);
    check("async ovf cut", OVF, 0);
    @(negedge Clk) RST = 1'b1;
    @(posedge Clk); #1;
    check("async resume2 out", OUT, 1);
    check("async resume2 tc", TC, 0);

    // Prescale 3 with EN dropped mid-period.
    check("ps reset out", ps_out, 0);
    @(negedge Clk) begin ps_rst = 1'b1; ps_en = 1'b1; end
    for (int k = 1; k <= 7; k++) begin
      @(posedge Clk); #1 check($sformatf("ps%0d out", k), ps_out, k / 3);
    end
    ps_en = 1'b0;
    repeat (5) @(posedge Clk);
    #1 check("ps hold out", ps_out, 2);
    ps_en = 1'b1;
    @(posedge Clk); #1 check("ps phase out a", ps_out, 2);
    @(posedge Clk); #1 check("ps phase out b", ps_out, 3);
    check("ps tc", ps_tc, 0);

    // Randomized traffic against the model.
    #1 RST = 1'b0;
    model_reset();
    dir_r = 1; mode_r = $urandom_range(0, 3);
    @(negedge Clk) RST = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (i > 0 && $urandom_range(0, 7) == 0) dir_r = !dir_r;
      if (i > 0 && $urandom_range(0, 19) == 0) mode_r = $urandom_range(0, 3);
      en_r   = ($urandom_range(0, 3) != 0);
      load_r = ($urandom_range(0, 19) == 0);
      lv_r   = $urandom_range(0, 15);
      clr_r  = ($urandom_range(0, 9) == 0);
      drive(en_r, load_r, lv_r, dir_r, mode_r, clr_r);
      @(posedge Clk);
      model_step(en_r, load_r, lv_r, dir_r, mode_r, clr_r);
      #1;
      check($sformatf("rnd%0d out", i), OUT, m_cnt);
      check($sformatf("rnd%0d tc", i), TC, m_tc);
      check($sformatf("rnd%0d ovf", i), OVF, m_ovf);
      check($sformatf("rnd%0d done", i), DONE, m_done);
      check($sformatf("rnd%0d dir_out", i), DIR_OUT, (mode_r == 2) ? m_pp_up : dir_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
